// File: rtl/fft_pkg.sv
// fft_pkg: shared widths, rounding constant and saturation bounds for the FFT datapath.
package fft_pkg;

    localparam int Q_DEF = 15;
    localparam int N_DEF = 256;

    function automatic int prod_w(input int qi, input int qd);
        return qi + qd + 2;
    endfunction

    function automatic longint rnd_k(input int qd);
        return longint'(1) << (qd - 1);
    endfunction

    function automatic longint sat_hi(input int q);
        return (longint'(1) << q) - 1;
    endfunction

    function automatic longint sat_lo(input int q);
        return -(longint'(1) << q);
    endfunction

endpackage

// File: rtl/fft_cmul.sv
// fft_cmul: two-cycle complex multiply b*W with half-up rounding back to data scale.
module fft_cmul
    import fft_pkg::*;
#(
    parameter int QI = Q_DEF,
    parameter int QD = Q_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_valid,
    input  logic [QI:0]   i_br,
    input  logic [QI:0]   i_bi,
    input  logic [QD:0]   i_wr,
    input  logic [QD:0]   i_wi,
    output logic          o_valid,
    output logic [QI+3:0] o_tr,
    output logic [QI+3:0] o_ti
);

    localparam int PW = prod_w(QI, QD);
    localparam int SW = PW + 1;
    localparam logic signed [SW-1:0] RND = SW'(rnd_k(QD));

    logic signed [PW-1:0] r_rr, r_ii, r_ri, r_ir;
    logic                 r_v1;
    logic signed [SW-1:0] w_tr, w_ti;

    always_comb begin
        w_tr = SW'(r_rr) - SW'(r_ii) + RND;
        w_ti = SW'(r_ri) + SW'(r_ir) + RND;
    end

    // Result keeps two headroom bits: (-1)*(-1) on both terms reaches +2^(QI+1).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr    <= '0;
            r_ii    <= '0;
            r_ri    <= '0;
            r_ir    <= '0;
            r_v1    <= 1'b0;
            o_tr    <= '0;
            o_ti    <= '0;
            o_valid <= 1'b0;
        end else begin
            r_rr    <= PW'($signed(i_br)) * PW'($signed(i_wr));
            r_ii    <= PW'($signed(i_bi)) * PW'($signed(i_wi));
            r_ri    <= PW'($signed(i_br)) * PW'($signed(i_wi));
            r_ir    <= PW'($signed(i_bi)) * PW'($signed(i_wr));
            r_v1    <= i_valid;
            o_tr    <= (QI + 4)'(w_tr >>> QD);
            o_ti    <= (QI + 4)'(w_ti >>> QD);
            o_valid <= r_v1;
        end
    end

endmodule

// File: rtl/fft_butterfly_r2.sv
// fft_butterfly_r2: pipelined radix-2 DIT butterfly (3-cycle latency) with frame
// counting and per-frame saturation reporting.
module fft_butterfly_r2
    import fft_pkg::*;
#(
    parameter int Q_IN   = Q_DEF,
    parameter int Q_DATA = Q_DEF,
    parameter int Q_OUT  = Q_DEF,
    parameter int N      = N_DEF,
    parameter int SCALE  = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_in,
    input  logic [Q_IN:0]   data_in_real_0,
    input  logic [Q_IN:0]   data_in_imag_0,
    input  logic [Q_IN:0]   data_in_real_1,
    input  logic [Q_IN:0]   data_in_imag_1,
    input  logic [Q_DATA:0] coeff_in_real,
    input  logic [Q_DATA:0] coeff_in_imag,
    output logic            valid_out,
    output logic [Q_OUT:0]  data_out_real_0,
    output logic [Q_OUT:0]  data_out_imag_0,
    output logic [Q_OUT:0]  data_out_real_1,
    output logic [Q_OUT:0]  data_out_imag_1,
    output logic            frame_done,
    output logic            frame_sat
);

    localparam int TW = Q_IN + 4;
    localparam int SW = Q_IN + 5;
    localparam int CW = (N > 2) ? $clog2(N / 2) : 1;
    localparam logic signed [SW-1:0] SAT_HI = SW'(sat_hi(Q_OUT));
    localparam logic signed [SW-1:0] SAT_LO = SW'(sat_lo(Q_OUT));

    logic [Q_IN:0]          r_a1r, r_a1i, r_a2r, r_a2i;
    logic [CW-1:0]          r_cnt;
    logic                   r_sticky;
    logic                   w_v2, w_last, w_clip;
    logic signed [TW-1:0]   w_tr, w_ti;
    logic signed [SW-1:0]   w_s [4];
    logic signed [SW-1:0]   w_k [4];
    logic [Q_OUT:0]         w_sat [4];

    fft_cmul #(.QI(Q_IN), .QD(Q_DATA)) u_cmul (
        .clk     (clk),
        .reset   (reset),
        .i_valid (valid_in),
        .i_br    (data_in_real_1),
        .i_bi    (data_in_imag_1),
        .i_wr    (coeff_in_real),
        .i_wi    (coeff_in_imag),
        .o_valid (w_v2),
        .o_tr    (w_tr),
        .o_ti    (w_ti)
    );

    always_comb begin
        w_s[0] = SW'($signed(r_a2r)) + SW'(w_tr);
        w_s[1] = SW'($signed(r_a2i)) + SW'(w_ti);
        w_s[2] = SW'($signed(r_a2r)) - SW'(w_tr);
        w_s[3] = SW'($signed(r_a2i)) - SW'(w_ti);
        w_clip = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_k[i]   = (SCALE != 0) ? (w_s[i] >>> 1) : w_s[i];
            w_sat[i] = (w_k[i] > SAT_HI) ? SAT_HI[Q_OUT:0] :
                       (w_k[i] < SAT_LO) ? SAT_LO[Q_OUT:0] : w_k[i][Q_OUT:0];
            w_clip   = w_clip | (w_k[i] > SAT_HI) | (w_k[i] < SAT_LO);
        end
        w_last = (r_cnt == CW'(N / 2 - 1));
    end

    // Sticky clears when the frame's last beat is reported, so a clip on the
    // following beat lands in the fresh frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a1r           <= '0;
            r_a1i           <= '0;
            r_a2r           <= '0;
            r_a2i           <= '0;
            r_cnt           <= '0;
            r_sticky        <= 1'b0;
            valid_out       <= 1'b0;
            frame_done      <= 1'b0;
            frame_sat       <= 1'b0;
            data_out_real_0 <= '0;
            data_out_imag_0 <= '0;
            data_out_real_1 <= '0;
            data_out_imag_1 <= '0;
        end else begin
            r_a1r      <= data_in_real_0;
            r_a1i      <= data_in_imag_0;
            r_a2r      <= r_a1r;
            r_a2i      <= r_a1i;
            valid_out  <= w_v2;
            frame_done <= w_v2 && w_last;
            frame_sat  <= w_v2 && w_last && (r_sticky || w_clip);
            if (w_v2) begin
                data_out_real_0 <= w_sat[0];
                data_out_imag_0 <= w_sat[1];
                data_out_real_1 <= w_sat[2];
                data_out_imag_1 <= w_sat[3];
                r_cnt           <= w_last ? '0 : r_cnt + CW'(1);
                r_sticky        <= !w_last && (r_sticky || w_clip);
            end
        end
    end

endmodule

// File: tb/tb_fft_butterfly_r2.sv
// tb_fft_butterfly_r2: three butterfly configurations driven in parallel and
// checked beat-by-beat against an ideal complex-arithmetic model.
module tb_fft_butterfly_r2;

    localparam int ND = 3;
    localparam int NH [ND] = '{4, 1, 2};
    localparam int SC [ND] = '{0, 0, 1};

    typedef struct {
        bit     v;
        int     id;
        longint ar, ai, br, bi, wr, wi;
    } beat_t;

    logic clk = 1'b0;
    logic reset;
    logic valid_in;
    logic [15:0] ar, ai, br, bi, wr, wi;
    logic [ND-1:0] vo, fd, fs;
    logic [ND-1:0][15:0] r0, i0, r1, i1;

    beat_t  q[$];
    longint last [ND][4];
    int     cnt [ND];
    bit     sat [ND];
    int     tests = 0;
    int     fails = 0;
    int     beat_id = 0;

    always #5 clk = ~clk;

    fft_butterfly_r2 #(.N(8), .SCALE(0)) dut0 (
        .clk(clk), .reset(reset), .valid_in(valid_in),
        .data_in_real_0(ar), .data_in_imag_0(ai), .data_in_real_1(br), .data_in_imag_1(bi),
        .coeff_in_real(wr), .coeff_in_imag(wi), .valid_out(vo[0]),
        .data_out_real_0(r0[0]), .data_out_imag_0(i0[0]), .data_out_real_1(r1[0]), .data_out_imag_1(i1[0]),
        .frame_done(fd[0]), .frame_sat(fs[0]));

    fft_butterfly_r2 #(.N(2), .SCALE(0)) dut1 (
        .clk(clk), .reset(reset), .valid_in(valid_in),
        .data_in_real_0(ar), .data_in_imag_0(ai), .data_in_real_1(br), .data_in_imag_1(bi),
        .coeff_in_real(wr), .coeff_in_imag(wi), .valid_out(vo[1]),
        .data_out_real_0(r0[1]), .data_out_imag_0(i0[1]), .data_out_real_1(r1[1]), .data_out_imag_1(i1[1]),
        .frame_done(fd[1]), .frame_sat(fs[1]));

    fft_butterfly_r2 #(.N(4), .SCALE(1)) dut2 (
        .clk(clk), .reset(reset), .valid_in(valid_in),
        .data_in_real_0(ar), .data_in_imag_0(ai), .data_in_real_1(br), .data_in_imag_1(bi),
        .coeff_in_real(wr), .coeff_in_imag(wi), .valid_out(vo[2]),
        .data_out_real_0(r0[2]), .data_out_imag_0(i0[2]), .data_out_real_1(r1[2]), .data_out_imag_1(i1[2]),
        .frame_done(fd[2]), .frame_sat(fs[2]));

    function automatic longint floor_div(input longint x, input longint d);
        longint r;
        r = x / d;
        if ((x % d) != 0 && x < 0) r = r - 1;
        return r;
    endfunction

    function automatic longint clip16(input longint x, inout bit c);
        if (x > 32767) begin c = 1'b1; return 32767; end
        if (x < -32768) begin c = 1'b1; return -32768; end
        return x;
    endfunction

    function automatic logic [66:0] observed(input int d);
        return {vo[d], fd[d], fs[d] & fd[d], r0[d], i0[d], r1[d], i1[d]};
    endfunction

    task automatic restart();
        beat_t idle;
        idle = '{v: 1'b0, id: -1, ar: 0, ai: 0, br: 0, bi: 0, wr: 0, wi: 0};
        q.delete();
        q.push_back(idle);
        q.push_back(idle);
        for (int d = 0; d < ND; d++) begin
            cnt[d] = 0;
            sat[d] = 1'b0;
            for (int k = 0; k < 4; k++) last[d][k] = 0;
        end
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < ND; d++) begin
            tests++;
            assert (observed(d) === 67'd0) else begin
                fails++;
                $error("FAIL %s dut%0d got=%h want=%h", tag, d, observed(d), 67'd0);
            end
        end
    endtask

    task automatic check_next();
        beat_t b;
        longint tr, ti;
        longint s [4];
        bit clip, done, fsat;
        logic [66:0] want;
        b = q.pop_front();
        tr = floor_div(b.br * b.wr - b.bi * b.wi + 16384, 32768);
        ti = floor_div(b.br * b.wi + b.bi * b.wr + 16384, 32768);
        for (int d = 0; d < ND; d++) begin
            done = 1'b0;
            fsat = 1'b0;
            if (b.v) begin
                s[0] = b.ar + tr;
                s[1] = b.ai + ti;
                s[2] = b.ar - tr;
                s[3] = b.ai - ti;
                clip = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    if (SC[d] != 0) s[k] = floor_div(s[k], 2);
                    last[d][k] = clip16(s[k], clip);
                end
                sat[d] = sat[d] | clip;
                cnt[d] = cnt[d] + 1;
                if (cnt[d] == NH[d]) begin
                    done = 1'b1;
                    fsat = sat[d];
                    cnt[d] = 0;
                    sat[d] = 1'b0;
                end
            end
            want = {b.v, done, fsat, 16'(last[d][0]), 16'(last[d][1]), 16'(last[d][2]), 16'(last[d][3])};
            tests++;
            assert (observed(d) === want) else begin
                fails++;
                $error("FAIL beat%0d dut%0d got=%h want=%h", b.id, d, observed(d), want);
            end
        end
    endtask

    task automatic step(input bit v, input longint a_r, input longint a_i, input longint b_r,
                        input longint b_i, input longint w_r, input longint w_i);
        beat_t b;
        b = '{v: v, id: v ? beat_id : -1, ar: a_r, ai: a_i, br: b_r, bi: b_i, wr: w_r, wi: w_i};
        if (v) beat_id++;
        valid_in = v;
        ar = 16'(a_r);
        ai = 16'(a_i);
        br = 16'(b_r);
        bi = 16'(b_i);
        wr = 16'(w_r);
        wi = 16'(w_i);
        q.push_back(b);
        @(posedge clk);
        #1;
        check_next();
    endtask

    function automatic longint rv();
        int sel;
        sel = int'($urandom_range(0, 7));
        return (sel == 0) ? -32768 : (sel == 1) ? 32767 : longint'($signed(16'($urandom)));
    endfunction

    task automatic rand_step();
        step($urandom_range(0, 3) != 0, rv(), rv(), rv(), rv(), rv(), rv());
    endtask

    initial begin
        reset = 1'b1;
        valid_in = 1'b0;
        {ar, ai, br, bi, wr, wi} = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_state");
        reset = 1'b0;
        restart();
        step(1, 1000, 0, 2000, 0, 32767, 0);
        step(1, 0, 0, 1000, 0, 0, -32768);
        step(1, 30000, 0, 30000, 0, 32767, 0);
        step(1, 0, 0, -32768, -32768, -32768, -32768);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 6; n++) step(1, rv(), rv(), rv(), rv(), rv(), rv());
        step(1, 5, 5, 7, 7, 100, 100);
        step(1, 9, 9, 11, 11, 200, 200);
        reset = 1'b1;
        valid_in = 1'b0;
        #1;
        check_zero("reset_async");
        repeat (2) begin
            @(posedge clk);
            #1;
            check_zero("reset_hold");
        end
        reset = 1'b0;
        restart();
        for (int n = 0; n < 4; n++) step(1, 123 * n, -7 * n, 4000, -3000, 23170, -23170);
        for (int n = 0; n < 250; n++) rand_step();
        repeat (3) step(0, 0, 0, 0, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
